// File: rtl/scancode_pkg.sv
// Shared constants and types for the PS/2 arrow-key scancode path.
package scancode_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CODE_W = 16;

    localparam logic [BYTE_W-1:0] PREFIX_EXT = 8'hE0;
    localparam logic [BYTE_W-1:0] PREFIX_BRK = 8'hF0;

    localparam logic [CODE_W-1:0] KEY_LEFT  = 16'hE06B;
    localparam logic [CODE_W-1:0] KEY_DOWN  = 16'hE072;
    localparam logic [CODE_W-1:0] KEY_RIGHT = 16'hE074;
    localparam logic [CODE_W-1:0] KEY_UP    = 16'hE075;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } state_t;

    // Held-key flag set, ordered {left, down, right, up}.
    typedef struct packed {
        logic left;
        logic down;
        logic right;
        logic up;
    } arrow_t;

endpackage

// File: rtl/arrow_key_decode.sv
// Maps an assembled scancode to a one-hot arrow-key hit vector.
module arrow_key_decode
    import scancode_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output arrow_t            hit_c
);

    always_comb begin
        hit_c = '0;
        case (code)
            KEY_LEFT:  hit_c.left  = 1'b1;
            KEY_DOWN:  hit_c.down  = 1'b1;
            KEY_RIGHT: hit_c.right = 1'b1;
            KEY_UP:    hit_c.up    = 1'b1;
            default:   hit_c = '0;
        endcase
    end

endmodule

// File: rtl/scancode_sequencer.sv
// Strips E0/F0 prefixes from a PS/2 byte stream, emits make/break scancodes,
// tracks held arrow keys and aborts stalled prefix sequences.
module scancode_sequencer
    import scancode_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              areset,
    input  logic [BYTE_W-1:0] in_byte,
    input  logic              in_valid,
    output logic [CODE_W-1:0] code,
    output logic              code_valid,
    output logic              code_break,
    output logic              err,
    output logic              left,
    output logic              down,
    output logic              right,
    output logic              up
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              emit_c;
    logic              brk_c;
    logic              ext_c;
    logic              err_c;
    logic [CODE_W-1:0] asm_code_c;
    arrow_t            hit_c;
    arrow_t            flags;
    arrow_t            flags_next;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state, watchdog and emit decision; an accepted byte always beats expiry.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        emit_c     = 1'b0;
        brk_c      = 1'b0;
        ext_c      = 1'b0;
        err_c      = 1'b0;
        if (in_valid) begin
            cnt_next = '0;
            case (state)
                S_IDLE: begin
                    if (in_byte == PREFIX_EXT)      state_next = S_EXT;
                    else if (in_byte == PREFIX_BRK) state_next = S_BRK;
                    else                            emit_c = 1'b1;
                end
                S_EXT: begin
                    if (in_byte == PREFIX_BRK)      state_next = S_EXT_BRK;
                    else if (in_byte != PREFIX_EXT) begin
                        emit_c     = 1'b1;
                        ext_c      = 1'b1;
                        state_next = S_IDLE;
                    end
                end
                S_BRK: begin
                    state_next = S_IDLE;
                    if (in_byte == PREFIX_EXT || in_byte == PREFIX_BRK) begin
                        err_c = 1'b1;
                    end else begin
                        emit_c = 1'b1;
                        brk_c  = 1'b1;
                    end
                end
                S_EXT_BRK: begin
                    state_next = S_IDLE;
                    if (in_byte == PREFIX_EXT || in_byte == PREFIX_BRK) begin
                        err_c = 1'b1;
                    end else begin
                        emit_c = 1'b1;
                        brk_c  = 1'b1;
                        ext_c  = 1'b1;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end else if (state != S_IDLE) begin
            if (cnt == CNT_MAX) begin
                err_c      = 1'b1;
                state_next = S_IDLE;
            end else begin
                cnt_next = cnt + CNT_W'(1);
            end
        end
        if (state_next == S_IDLE) begin
            cnt_next = '0;
        end
    end

    assign asm_code_c = {(ext_c ? PREFIX_EXT : BYTE_W'(0)), in_byte};

    arrow_key_decode u_decode (
        .code  (asm_code_c),
        .hit_c (hit_c)
    );

    always_comb begin
        flags_next = flags;
        if (emit_c) begin
            if (brk_c) flags_next = flags & ~hit_c;
            else       flags_next = flags | hit_c;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            code       <= '0;
            code_valid <= 1'b0;
            code_break <= 1'b0;
            err        <= 1'b0;
            flags      <= '0;
        end else begin
            code_valid <= emit_c;
            err        <= err_c;
            flags      <= flags_next;
            if (emit_c) begin
                code       <= asm_code_c;
                code_break <= brk_c;
            end
        end
    end

    assign left  = flags.left;
    assign down  = flags.down;
    assign right = flags.right;
    assign up    = flags.up;

endmodule

// File: tb/tb_scancode_sequencer.sv
// Scoreboard bench for scancode_sequencer: directed byte vectors push expected
// events; a negedge monitor pops and compares whenever code_valid or err fires.
module tb_scancode_sequencer;

    localparam int unsigned TMO = 8;
    localparam int K_NONE = 0;
    localparam int K_CODE = 1;
    localparam int K_ERR  = 2;

    logic        clk = 1'b0;
    logic        areset;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic [15:0] code;
    logic        code_valid;
    logic        code_break;
    logic        err;
    logic        left;
    logic        down;
    logic        right;
    logic        up;

    typedef struct {
        bit          is_err;
        logic [15:0] code;
        bit          brk;
        logic [3:0]  flags;
        int          due;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    scancode_sequencer #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .areset     (areset),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .code       (code),
        .code_valid (code_valid),
        .code_break (code_break),
        .err        (err),
        .left       (left),
        .down       (down),
        .right      (right),
        .up         (up)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every output pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!areset && (code_valid || err)) begin
            chk("valid_err_exclusive", 32'(code_valid & err), 32'd0);
            if (q.size() == 0) begin
                chk("unexpected_output", {14'd0, code_valid, err, code}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("err_pulse", 32'(err), 32'(e.is_err));
                chk("code_valid_pulse", 32'(code_valid), 32'(!e.is_err));
                chk("latency", 32'(cyc), 32'(e.due));
                if (!e.is_err) begin
                    chk("code", 32'(code), 32'(e.code));
                    chk("code_break", 32'(code_break), 32'(e.brk));
                end
                chk("flags", 32'({left, down, right, up}), 32'(e.flags));
            end
        end
    end

    // Called at a negedge; drives one byte and idles the requested number of cycles.
    task automatic send(input logic [7:0] b, input int idle, input int kind,
                        input logic [15:0] c, input bit brk, input logic [3:0] fl);
        exp_t e;
        in_byte  = b;
        in_valid = 1'b1;
        if (kind != K_NONE) begin
            e.is_err = (kind == K_ERR);
            e.code   = c;
            e.brk    = brk;
            e.flags  = fl;
            e.due    = cyc + 1;
            q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (idle) @(negedge clk);
    endtask

    task automatic send_prefix_then_stall(input logic [3:0] fl);
        exp_t e;
        in_byte  = 8'hE0;
        in_valid = 1'b1;
        e.is_err = 1'b1;
        e.code   = 16'h0;
        e.brk    = 1'b0;
        e.flags  = fl;
        e.due    = cyc + 1 + TMO;
        q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (TMO + 4) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_code"}, 32'(code), 32'd0);
        chk({tag, "_code_valid"}, 32'(code_valid), 32'd0);
        chk({tag, "_code_break"}, 32'(code_break), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_flags"}, 32'({left, down, right, up}), 32'd0);
    endtask

    initial begin
        areset   = 1'b1;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        areset = 1'b0;
        @(negedge clk);

        // Extended make then break of left arrow
        send(8'hE0, 3, K_NONE, 16'h0,    1'b0, 4'b0000);
        send(8'h6B, 3, K_CODE, 16'hE06B, 1'b0, 4'b1000);
        send(8'hE0, 3, K_NONE, 16'h0,    1'b0, 4'b0000);
        send(8'hF0, 3, K_NONE, 16'h0,    1'b0, 4'b0000);
        send(8'h6B, 3, K_CODE, 16'hE06B, 1'b1, 4'b0000);

        // Plain make and break
        send(8'h1C, 3, K_CODE, 16'h001C, 1'b0, 4'b0000);
        send(8'hF0, 3, K_NONE, 16'h0,    1'b0, 4'b0000);
        send(8'h1C, 3, K_CODE, 16'h001C, 1'b1, 4'b0000);

        // Up and right held together, then release up
        send(8'hE0, 2, K_NONE, 16'h0,    1'b0, 4'b0000);
        send(8'h75, 2, K_CODE, 16'hE075, 1'b0, 4'b0001);
        send(8'hE0, 2, K_NONE, 16'h0,    1'b0, 4'b0000);
        send(8'h74, 2, K_CODE, 16'hE074, 1'b0, 4'b0011);
        send(8'hE0, 2, K_NONE, 16'h0,    1'b0, 4'b0000);
        send(8'hF0, 2, K_NONE, 16'h0,    1'b0, 4'b0000);
        send(8'h75, 2, K_CODE, 16'hE075, 1'b1, 4'b0010);

        // Stalled prefix times out; next byte starts fresh from IDLE
        send_prefix_then_stall(4'b0010);
        send(8'h6B, 3, K_CODE, 16'h006B, 1'b0, 4'b0010);

        // Break prefix followed by extended prefix is a protocol error
        send(8'hF0, 2, K_NONE, 16'h0,    1'b0, 4'b0000);
        send(8'hE0, 3, K_ERR,  16'h0,    1'b0, 4'b0010);

        // Byte lands on the exact expiry cycle
        send(8'hE0, TMO - 1, K_NONE, 16'h0, 1'b0, 4'b0000);
        send(8'h72, 3, K_CODE, 16'hE072, 1'b0, 4'b0110);

        // Repeated E0 and double F0
        send(8'hE0, 1, K_NONE, 16'h0,    1'b0, 4'b0000);
        send(8'hE0, 1, K_NONE, 16'h0,    1'b0, 4'b0000);
        send(8'h6B, 2, K_CODE, 16'hE06B, 1'b0, 4'b1110);
        send(8'hE0, 1, K_NONE, 16'h0,    1'b0, 4'b0000);
        send(8'hF0, 1, K_NONE, 16'h0,    1'b0, 4'b0000);
        send(8'hF0, 2, K_ERR,  16'h0,    1'b0, 4'b1110);

        // Back-to-back bytes at full rate
        send(8'hE0, 0, K_NONE, 16'h0,    1'b0, 4'b0000);
        send(8'hF0, 0, K_NONE, 16'h0,    1'b0, 4'b0000);
        send(8'h74, 0, K_CODE, 16'hE074, 1'b1, 4'b1100);
        send(8'h1C, 3, K_CODE, 16'h001C, 1'b0, 4'b1100);

        // Reset mid-sequence drops the prefix and the held flags
        send(8'hE0, 2, K_NONE, 16'h0, 1'b0, 4'b0000);
        areset = 1'b1;
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        areset = 1'b0;
        @(negedge clk);
        send(8'h72, 3, K_CODE, 16'h0072, 1'b0, 4'b0000);

        repeat (20) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scancode_sequencer.md
# scancode_sequencer

Front-end controller for the keyboard arrow-key path. It consumes a stream of PS/2 data bytes, strips the extended (0xE0) and break (0xF0) prefixes, and emits one assembled 16-bit scancode per key event with a make/break flag. It also maintains level-held pressed flags for the four arrow keys, feeding the game/cursor logic. A watchdog aborts any prefix sequence that stalls.

## Interface
- TIMEOUT, 1000: cycles allowed between bytes of one prefixed sequence before abort; ≥2.

Ports:
- clk  in  1  system clock, all logic on rising edge
- areset  in  1  asynchronous, active-high reset
- in_byte  in  8  received PS/2 data byte
- in_valid  in  1  single-cycle strobe: in_byte valid this cycle
- code  out  16  assembled scancode: {0xE0 or 0x00, final byte}
- code_valid  out  1  one-cycle pulse: code/code_break valid
- code_break  out  1  1 = key release, 0 = key press; valid with code_valid
- err  out  1  one-cycle pulse: protocol error or timeout
- left, down, right, up  out  1 each  arrow key currently held

## Operation
- States: IDLE, EXT (seen E0), BRK (seen F0), EXT_BRK (seen E0 F0).
- IDLE: E0→EXT; F0→BRK; other byte b→emit {00,b} make, stay IDLE.
- EXT: F0→EXT_BRK; E0→stay EXT (watchdog restarted); other b→emit {E0,b} make, →IDLE.
- BRK: E0 or F0→err, →IDLE; other b→emit {00,b} break, →IDLE.
- EXT_BRK: E0 or F0→err, →IDLE; other b→emit {E0,b} break, →IDLE.
- Bytes ignored unless in_valid=1.
- Held flags: on emit of E06B/E072/E074/E075, set (make) or clear (break) left/down/right/up respectively. Other codes leave flags unchanged. Several flags may be 1 at once.
- Watchdog: counter cleared on every accepted byte and whenever state is IDLE. Increments each cycle in non-IDLE states with in_valid=0. When counter = TIMEOUT-1 with in_valid=0: err pulse, →IDLE, pending prefix discarded, no code emitted.
- Simultaneous in_valid and expiry: the byte wins, processed normally, no err.
- Held flags are never changed by err or timeout.

## Timing
- Reset (async assert, sync release): state IDLE, counter 0, code=0, code_valid=0, code_break=0, err=0, left=down=right=up=0.
- All outputs registered. Latency: code_valid, code, code_break and flag update appear exactly 1 cycle after the in_valid cycle carrying the final byte.
- err asserted 1 cycle after the offending byte, or the cycle after the counter reaches TIMEOUT-1.
- code/code_break hold their last value between pulses.
- code_valid and err never assert in the same cycle.
- Back-to-back in_valid every cycle is supported at full rate, with no stall and no ready signal.
- areset mid-sequence: partial prefix lost, flags cleared; the next byte is treated from IDLE.

## Structure
- Shared package scancode_pkg:
  - PREFIX_EXT=8'hE0, PREFIX_BRK=8'hF0.
  - KEY_LEFT=16'hE06B, KEY_DOWN=16'hE072, KEY_RIGHT=16'hE074, KEY_UP=16'hE075.
  - State enum type.
- Sub-module arrow_key_decode: combinational, 16-bit code → 4-bit one-hot {left,down,right,up}, all zero for non-arrow codes. It uses default assignments so no latches are inferred. The sequencer instantiates it on the assembled code.
- Watchdog width: $clog2(TIMEOUT).

## Test plan
- Bytes E0,6B then E0,F0,6B (in_valid gaps of 3 cycles): code_valid pulses with code=E06B, code_break=0, left=1; then code=E06B, code_break=1, left=0.
- Plain byte 1C: code=001C, code_break=0, 1 cycle after strobe; F0,1C → code=001C, code_break=1; arrow flags unchanged.
- E0,75 then E0,74 then E0,F0,75: up=1, right=1 simultaneously; after break, up=0, right=1.
- TIMEOUT=8; send E0 then idle: err pulses once, state IDLE; next 6B yields code=006B make; no arrow flag set.
- F0 followed by E0: err pulse, no code_valid. Byte arriving on the exact expiry cycle is processed with no err. areset asserted between E0 and 72: all outputs 0; following 72 gives code=0072.
